sum_accumulator: RTL and testbench

- Downstream stage of the 9-bit registered adder.
- Collects successive sums, adds COUNT of them into one wider frame total, and presents the total on a valid/ready output with a 1-deep output register.
- The accumulation engine keeps running while a previous total waits for the consumer.
- A flush input closes a partial frame early.

---
 rtl/sum_accumulator.sv | 111 +++++++++++
 tb/tb_sum_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates COUNT adder sums per frame onto a 1-deep valid/ready output
// Optional SUM_ACCUM_FRAME_ID_EN adds a 4-bit wrapping frame id output (out_id).
module sum_accumulator #(
  parameter int IN_W  = 9,
  parameter int COUNT = 4,
  parameter int CNT_W = 3,
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SUM_ACCUM_FRAME_ID_EN
  ,
  output logic [3:0]       out_id
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             out_free;
  logic             close;
  logic             emit;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;

  // Only the sample that would complete a frame is stalled; earlier samples keep accumulating.
  assign in_ready = ~(out_valid_q & ~out_ready & (cnt_q == LAST));
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;
  assign close    = (accept & (cnt_q == LAST)) |
                    ((flush | flush_pend_q) & ((cnt_q != '0) | accept));
  assign emit     = close & out_free;
  assign acc_sum  = acc_q + (accept ? {{(ACC_W-IN_W){1'b0}}, in_data} : '0);
  assign cnt_inc  = cnt_q + {{(CNT_W-1){1'b0}}, accept};

  always_comb begin
    acc_d        = acc_sum;
    cnt_d        = cnt_inc;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_cnt_d    = out_cnt_q;
    out_valid_d  = out_valid_q;
    if (emit) begin
      out_data_d   = acc_sum;
      out_cnt_d    = cnt_inc;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      // A flush that cannot be stored yet is remembered; later samples still join the frame.
      if (close) flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_cnt_q    <= out_cnt_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;

`ifdef SUM_ACCUM_FRAME_ID_EN
  logic [3:0] frame_seq_q;
  logic [3:0] out_id_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_seq_q <= '0;
      out_id_q    <= '0;
    end else if (emit) begin
      out_id_q    <= frame_seq_q;
      frame_seq_q <= frame_seq_q + 4'd1;
    end
  end

  assign out_id = out_id_q;
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard bench for sum_accumulator with a frame-level reference model
module tb_sum_accumulator;
  localparam int COUNT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [10:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef SUM_ACCUM_FRAME_ID_EN
  logic [3:0]  out_id;
`endif

  sum_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_data (out_data),
    .out_cnt  (out_cnt),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SUM_ACCUM_FRAME_ID_EN
    ,
    .out_id   (out_id)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int cnt;
    int id;
  } frame_t;

  frame_t exp_q[$];
  frame_t log_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference: the open frame as a running sum and sample count, plus whether a total is held.
  int m_sum, m_cnt, m_seq;
  bit m_pend, m_held;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sum <= 0; m_cnt <= 0; m_seq <= 0; m_pend <= 0; m_held <= 0;
      exp_q.delete();
    end else begin : model
      int s, c;
      bit acc, free, cl;
      frame_t f;
      s = m_sum;
      c = m_cnt;
      free = !m_held || out_ready;
      acc = in_valid && !(m_held && !out_ready && c == COUNT - 1);
      if (acc) begin
        s = s + int'(in_data);
        c = c + 1;
      end
      cl = (c == COUNT) || ((flush || m_pend) && c != 0);
      if (cl && free) begin
        f.data = s; f.cnt = c; f.id = m_seq;
        exp_q.push_back(f);
        m_seq <= (m_seq + 1) % 16;
        m_sum <= 0; m_cnt <= 0; m_pend <= 0; m_held <= 1;
      end else begin
        m_sum <= s;
        m_cnt <= c;
        if (m_held && out_ready) m_held <= 0;
        if (cl) m_pend <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("out_valid", int'(out_valid), int'(m_held));
      chk("in_ready", int'(in_ready), int'(!(m_held && !out_ready && m_cnt == COUNT - 1)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin : cmp
          frame_t f;
          chk("out_data", int'(out_data), exp_q[0].data);
          chk("out_cnt", int'(out_cnt), exp_q[0].cnt);
`ifdef SUM_ACCUM_FRAME_ID_EN
          chk("out_id", int'(out_id), exp_q[0].id);
          f.id = int'(out_id);
`else
          f.id = 0;
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            f.data = int'(out_data);
            f.cnt = int'(out_cnt);
            log_q.push_back(f);
          end
        end
      end
    end
  end

  task automatic step(bit v, int d, bit f, bit r);
    in_valid = v; in_data = 9'(d); flush = f; out_ready = r;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic send(int d, bit r);
    int n;
    bit a;
    n = 0;
    in_valid = 1'b1; in_data = 9'(d); flush = 1'b0; out_ready = r;
    forever begin
      #1 a = in_ready;
      @(posedge clk); #1;
      if (a) break;
      n++;
      if (n > 20) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  task automatic chk_log(string nm, int back, int data, int cnt);
    if (log_q.size() < back) chk({nm, "_present"}, log_q.size(), back);
    else begin
      chk({nm, "_data"}, log_q[log_q.size() - back].data, data);
      chk({nm, "_cnt"}, log_q[log_q.size() - back].cnt, cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic frame and latency
    send(10, 1); send(20, 1); send(30, 1); send(40, 1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 100);
    chk("t1_cnt", int'(out_cnt), 4);
    step(0, 0, 0, 1);
    chk("t1_valid_drop", int'(out_valid), 0);

    // Maximum sample values
    for (int i = 0; i < 4; i++) send(511, 1);
    idle(2);
    chk_log("t2", 1, 2044, 4);

    // Backpressure with stall of the frame-completing sample
    for (int i = 0; i < 4; i++) send(1, 0);
    for (int i = 0; i < 3; i++) send(2, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2, 0, 0);
      chk("t3_stall", int'(in_ready), 0);
      chk("t3_held_data", int'(out_data), 4);
    end
    send(2, 1);
    chk("t3_nobubble_valid", int'(out_valid), 1);
    chk("t3_second_data", int'(out_data), 8);
    idle(2);
    chk_log("t3_first", 2, 4, 4);
    chk_log("t3_second", 1, 8, 4);

    // Flush of a partial frame, then a flush with an empty frame
    send(5, 1); send(7, 1);
    step(0, 0, 1, 1);
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_data", int'(out_data), 12);
    chk("t4_cnt", int'(out_cnt), 2);
    step(0, 0, 0, 1);
    base = log_q.size();
    step(0, 0, 1, 1);
    chk("t4_empty_flush", int'(out_valid), 0);
    idle(2);
    chk("t4_no_emit", log_q.size(), base);

    // Flush while the output register is held
    for (int i = 0; i < 4; i++) send(1, 0);
    send(3, 0);
    step(0, 0, 1, 0);
    send(4, 0);
    chk("t5_still_old", int'(out_data), 4);
    step(0, 0, 0, 1);
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_data", int'(out_data), 7);
    chk("t5_cnt", int'(out_cnt), 2);
    idle(2);
    chk_log("t5_old", 2, 4, 4);
    chk_log("t5_new", 1, 7, 2);

    // Async reset mid-frame, asserted between edges
    send(9, 1); send(9, 1);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_data", int'(out_data), 0);
    chk("t6_rst_cnt", int'(out_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    send(1, 1); send(2, 1); send(3, 1); send(4, 1);
    chk("t6_data", int'(out_data), 10);
    chk("t6_cnt", int'(out_cnt), 4);
`ifdef SUM_ACCUM_FRAME_ID_EN
    chk("t6_id", int'(out_id), 0);
    for (int fr = 0; fr < 16; fr++)
      for (int i = 0; i < 4; i++) send(fr, 1);
    chk("t6_id_wrap", int'(out_id), 0);
`endif
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 511),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
    idle(6);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
